// File: rtl/fetch_unit_if.sv
// Signal bundle between the fetch stage and its surroundings: ID-stage control,
// instruction memory, the IF/ID register outputs and RAS status.
interface fetch_unit_if #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16
);
  logic               stall;
  logic [1:0]         PcSrc;
  logic               kill;
  logic               is_call;
  logic [PC_W-1:0]    jump_target;
  logic [PC_W-1:0]    branch_target;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] IF_ID_instr;
  logic [PC_W-1:0]    IF_ID_pc;
  logic               IF_ID_valid;
  logic [PC_W-1:0]    ret_addr;
  logic               ras_overflow;
  logic               ras_underflow;

  // The fetch unit is the slave; ID control and instruction memory act as master.
  modport slave (
    input  stall, PcSrc, kill, is_call, jump_target, branch_target, imem_data,
    output imem_addr, IF_ID_instr, IF_ID_pc, IF_ID_valid, ret_addr,
           ras_overflow, ras_underflow
  );

  modport master (
    output stall, PcSrc, kill, is_call, jump_target, branch_target, imem_data,
    input  imem_addr, IF_ID_instr, IF_ID_pc, IF_ID_valid, ret_addr,
           ras_overflow, ras_underflow
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage with IF/ID pipeline register and a circular
// return-address stack for CALL/RET redirects.
module fetch_unit #(
  parameter int               PC_W      = 16,
  parameter int               INSTR_W   = 16,
  parameter int               RAS_DEPTH = 8,
  parameter logic [PC_W-1:0]  RESET_PC  = 16'h0000,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h0000
) (
  input logic        clk,
  input logic        reset,
  fetch_unit_if.slave bus
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    SRC_SEQ    = 2'd0,
    SRC_JUMP   = 2'd1,
    SRC_BRANCH = 2'd2,
    SRC_RAS    = 2'd3
  } pc_src_e;

  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_if_instr;
  logic [PC_W-1:0]    r_if_pc;
  logic               r_if_valid;

  logic [PC_W-1:0]    r_ras [RAS_DEPTH];
  logic [PTR_W-1:0]   r_sp;       // next free slot; top lives at r_sp-1
  logic [CNT_W-1:0]   r_count;
  logic               r_overflow;
  logic               r_underflow;

  pc_src_e            w_src;
  logic               w_redirect;
  logic               w_push;
  logic               w_pop;
  logic               w_ras_empty;
  logic               w_ras_full;
  logic [PTR_W-1:0]   w_top_idx;
  logic [PC_W-1:0]    w_ras_top;
  logic [PC_W-1:0]    w_pc_inc;
  logic [PC_W-1:0]    w_ret_push;
  logic [PC_W-1:0]    w_next_pc;

  assign w_src       = pc_src_e'(bus.PcSrc);
  assign w_redirect  = bus.kill & ~bus.stall;
  assign w_push      = w_redirect && (w_src == SRC_JUMP) && bus.is_call;
  assign w_pop       = w_redirect && (w_src == SRC_RAS);
  assign w_ras_empty = (r_count == '0);
  assign w_ras_full  = (r_count == CNT_W'(RAS_DEPTH));
  assign w_top_idx   = r_sp - 1'b1;
  assign w_ras_top   = w_ras_empty ? '0 : r_ras[w_top_idx];
  assign w_pc_inc    = r_pc + 1'b1;
  assign w_ret_push  = r_if_pc + 1'b1;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_next_pc = w_pc_inc;
    if (w_redirect) begin
      unique case (w_src)
        SRC_SEQ:    w_next_pc = w_pc_inc;
        SRC_JUMP:   w_next_pc = bus.jump_target;
        SRC_BRANCH: w_next_pc = bus.branch_target;
        SRC_RAS:    w_next_pc = w_ras_empty ? RESET_PC : w_ras_top;
        default:    w_next_pc = w_pc_inc;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_if_instr <= NOP_INSTR;
      r_if_pc    <= '0;
      r_if_valid <= 1'b0;
    end else if (!bus.stall) begin
      r_pc <= w_next_pc;
      if (w_redirect) begin
        r_if_instr <= NOP_INSTR;
        r_if_pc    <= r_pc;
        r_if_valid <= 1'b0;
      end else begin
        r_if_instr <= bus.imem_data;
        r_if_pc    <= r_pc;
        r_if_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sp        <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (w_push) begin
      // A full stack wraps onto its oldest slot, so the count saturates.
      r_sp <= r_sp + 1'b1;
      if (w_ras_full) begin
        r_overflow <= 1'b1;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end else if (w_pop) begin
      if (w_ras_empty) begin
        r_underflow <= 1'b1;
      end else begin
        r_sp    <= w_top_idx;
        r_count <= r_count - 1'b1;
      end
    end
  end

  // NOTE: the RAS storage is left unreset; r_count gates every read, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_ras[r_sp] <= w_ret_push;
    end
  end

  assign bus.imem_addr     = r_pc;
  assign bus.IF_ID_instr   = r_if_instr;
  assign bus.IF_ID_pc      = r_if_pc;
  assign bus.IF_ID_valid   = r_if_valid;
  assign bus.ret_addr      = w_ras_top;
  assign bus.ras_overflow  = r_overflow;
  assign bus.ras_underflow = r_underflow;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage and IF/ID pipeline register; the consumer of the PC-select, kill and stall outputs driven by the ID-stage control logic.
- Holds the PC, drives the instruction-memory address, and latches the fetched instruction with its PC into IF/ID.
- Applies jump, call, branch and return redirects, and inserts a bubble on kill.
- Owns an internal return-address stack (RAS): CALL pushes onto it and RET pops from it.

Parameters:
- PC_W, 16, PC and instruction-address width (word addressed, +1 per instruction)
- INSTR_W, 16, instruction width
- RAS_DEPTH, 8, return-address stack entries (power of 2, ≥2)
- RESET_PC, 16'h0000, PC after reset and after a RAS underflow
- NOP_INSTR, 16'h0000, bubble encoding loaded into IF/ID on kill

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- stall  in  1  load-use stall from hazard detection; holds the PC and IF/ID
- PcSrc  in  2  next-PC select: 0 = PC+1, 1 = jump_target (JMP/CALL), 2 = branch_target, 3 = RAS top (RET)
- kill  in  1  redirect taken in ID; flush IF/ID
- is_call  in  1  the ID-stage instruction is CALL; qualifies the RAS push
- jump_target  in  PC_W  absolute JMP/CALL target from ID
- branch_target  in  PC_W  PC-relative branch target from ID
- imem_addr  out  PC_W  instruction-memory address (= PC register, combinational)
- imem_data  in  INSTR_W  instruction returned combinationally for imem_addr
- IF_ID_instr  out  INSTR_W  latched instruction
- IF_ID_pc  out  PC_W  PC of the latched instruction
- IF_ID_valid  out  1  0 for a bubble
- ret_addr  out  PC_W  current RAS top (debug/visibility)
- ras_overflow  out  1  sticky: a push occurred while the RAS was full
- ras_underflow  out  1  sticky: a pop occurred while the RAS was empty

Behaviour:
- Reset (asynchronous, takes effect immediately, also mid-operation):
  - PC = RESET_PC; IF_ID_instr = NOP_INSTR; IF_ID_pc = 0; IF_ID_valid = 0.
  - RAS pointer and count = 0; ras_overflow = 0; ras_underflow = 0; ret_addr = 0.
- Redirect condition: redirect = kill && !stall. kill with PcSrc=0 is treated as a flush only, and next PC = PC+1.
- Per rising edge, evaluated in priority order:
  1. stall=1: PC, IF/ID and RAS all hold. kill, PcSrc and is_call are ignored. The ID instruction is re-presented once the stall drops, so no double push or pop can occur.
  2. redirect:
     - PC <= selected target.
     - IF/ID <= {NOP_INSTR, PC, valid=0}, so exactly one bubble is inserted.
     - The fetched imem_data is discarded.
  3. Otherwise: IF_ID_instr <= imem_data; IF_ID_pc <= PC; IF_ID_valid <= 1; PC <= PC+1.
- PC arithmetic: modulo 2^PC_W, so PC+1 from all-ones wraps to 0.
- RAS push: occurs when redirect && PcSrc==1 && is_call.
  - Pushes IF_ID_pc+1, the return address of the CALL in ID.
  - If full (count == RAS_DEPTH): the oldest entry is overwritten (circular), count stays at RAS_DEPTH, and ras_overflow is set.
- RAS pop: occurs when redirect && PcSrc==3.
  - Next PC = top entry; count decrements.
  - If empty: next PC = RESET_PC, count stays 0, and ras_underflow is set.
- RAS interaction rules:
  - is_call with PcSrc≠1 has no RAS effect.
  - A push and a pop cannot coincide, because PcSrc selects exactly one source.
- ret_addr: combinational top-of-stack; 0 when empty.
- Latency:
  - One cycle from a redirect edge to the target appearing on imem_addr.
  - The target instruction appears in IF/ID on the following edge, so a taken redirect costs exactly one bubble.

Test Plan:
- Reset, then run 4 cycles with the instruction memory holding 16'h1111..16'h4444 at addresses 0..3 → imem_addr 0,1,2,3; IF_ID_valid goes 0→1; IF_ID_instr=16'h1111 with IF_ID_pc=0 after the first edge.
- Assert stall for 2 cycles at PC=5 → PC stays 5 and IF/ID is unchanged. Asserting kill=1, PcSrc=2 during the stall causes no redirect. After the stall drops, the same kill redirects to branch_target=16'h0040 with one bubble (IF_ID_valid=0).
- CALL at IF_ID_pc=16'h0010 with kill=1, PcSrc=1, is_call=1, jump_target=16'h0100 → PC=16'h0100 and ret_addr=16'h0011. A later RET (kill=1, PcSrc=3) → PC=16'h0011 and the RAS is empty.
- Nine nested CALLs with RAS_DEPTH=8 → ras_overflow=1. Eight RETs then return correctly for the newest 8 entries. A ninth RET → PC=RESET_PC and ras_underflow=1.
- Assert reset mid-redirect, with kill high and the RAS holding 3 entries → all outputs take their reset values immediately, without waiting for a clock edge. Afterwards a RET underflows.
- PC=16'hFFFF with no redirect → next imem_addr = 16'h0000.
